dac_write_ctrl: RTL and testbench

Owns the 8-bit DAC output code and sequences every parallel write to the external DAC chip (CS_N/WR_N strobe with programmable setup, pulse and hold times). Code changes come from the up, down and mid push-buttons and from an internal ramp generator, applied in a fixed priority. The committed code is exported as dac_val for the text-LCD display block.

---
 rtl/dac_write_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dac_write_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_ctrl.sv
// dac_write_ctrl: owns the 8-bit DAC code and sequences CS_N/WR_N parallel writes.
// Build option: define DAC_TRIANGLE_EN for a triangle ramp (default: sawtooth ramp).
module dac_write_ctrl #(
    parameter int         SETUP_CYC  = 2,
    parameter int         PULSE_CYC  = 3,
    parameter int         HOLD_CYC   = 2,
    parameter int         RAMP_DIV   = 1000,
    parameter logic [7:0] RESET_CODE = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mid,
    input  logic       ramp_en,
    output logic       dac_cs_n,
    output logic       dac_wr_n,
    output logic [7:0] dac_data,
    output logic [7:0] dac_val,
    output logic       busy,
    output logic       done
);
    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam int DW = $clog2(RAMP_DIV);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] div;
    logic [3:0]    sync1, sync2;
    logic [2:0]    prev, rise;
    logic [3:0]    req, pend, pend_n;
    logic          ramp_on, tick_hit, init, init_n, last, tick_take;
    logic [7:0]    code, code_n, tick_code;

    // request bit order everywhere: {mid, up, down, tick}
    assign ramp_on  = sync2[0];
    assign rise     = sync2[3:1] & ~prev;
    assign tick_hit = ramp_on && (div == DIV_LAST);
    assign req      = (pend & {3'b111, ramp_on})
                    | {rise[2], rise[1] & ~ramp_on, rise[0] & ~ramp_on, tick_hit};
    assign last     = (state == SETUP  && cnt == SETUP_LAST)
                   || (state == STROBE && cnt == PULSE_LAST)
                   || (state == HOLD   && cnt == HOLD_LAST);
    assign dac_val  = code;
    assign dac_data = code;

    // two-flop synchronizer plus previous-level register for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {btn_mid, btn_up, btn_down, ramp_en};
            sync2 <= sync1;
            prev  <= sync2[3:1];
        end
    end

    // ramp divider: free-runs 0..RAMP_DIV-1 while the ramp is enabled, parked at 0 otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div <= '0;
        else
            div <= (!ramp_on || tick_hit) ? '0 : div + 1'b1;
    end

`ifdef DAC_TRIANGLE_EN
    logic dir;
    logic mid_take;
    assign mid_take  = state == IDLE && !init && req[3];
    assign tick_code = dir ? ((code == 8'hFF) ? 8'hFE : code + 8'd1)
                           : ((code == 8'h00) ? 8'h01 : code - 8'd1);
    // ramp direction: mid forces up, a consumed tick reverses at either end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dir <= 1'b1;
        else if (mid_take)
            dir <= 1'b1;
        else if (tick_take)
            dir <= dir ? (code != 8'hFF) : (code == 8'h00);
    end
`else
    assign tick_code = code + 8'd1;
`endif

    // next state, request arbitration and new code, committed only when leaving IDLE
    always_comb begin
        state_n   = state;
        cnt_n     = (state == IDLE || last) ? '0 : cnt + 1'b1;
        pend_n    = req;
        init_n    = init;
        code_n    = code;
        tick_take = 1'b0;
        if (state == IDLE) begin
            if (init) begin
                code_n  = RESET_CODE;
                init_n  = 1'b0;
                state_n = SETUP;
            end else if (req[3]) begin
                code_n  = RESET_CODE;
                pend_n  = '0;
                state_n = SETUP;
            end else if (req[2] && req[1]) begin
                pend_n[2:1] = 2'b00;
                tick_take   = req[0];
            end else if (req[2]) begin
                code_n    = (code == 8'hFF) ? code : code + 8'd1;
                pend_n[2] = 1'b0;
                state_n   = SETUP;
            end else if (req[1]) begin
                code_n    = (code == 8'h00) ? code : code - 8'd1;
                pend_n[1] = 1'b0;
                state_n   = SETUP;
            end else begin
                tick_take = req[0];
            end
            if (tick_take) begin
                code_n    = tick_code;
                pend_n[0] = 1'b0;
                state_n   = SETUP;
            end
        end else if (last) begin
            state_n = (state == SETUP) ? STROBE : (state == STROBE) ? HOLD : IDLE;
        end
    end

    // state register with registered, glitch-free DAC strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= '0;
            init     <= 1'b1;
            code     <= RESET_CODE;
            dac_cs_n <= 1'b1;
            dac_wr_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend     <= pend_n;
            init     <= init_n;
            code     <= code_n;
            dac_cs_n <= state_n == IDLE;
            dac_wr_n <= state_n != STROBE;
            busy     <= state_n != IDLE;
            done     <= state == HOLD && state_n == IDLE;
        end
    end
endmodule

// File: tb/tb_dac_write_ctrl.sv
// tb_dac_write_ctrl: directed self-checking bench for dac_write_ctrl (RAMP_DIV=16).
module tb_dac_write_ctrl;
    logic       clk = 1'b0, rst = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_mid = 1'b0, ramp_en = 1'b0;
    logic       dac_cs_n, dac_wr_n, busy, done;
    logic [7:0] dac_data, dac_val;
    int         checks = 0, failures = 0;
    int         wr_count = 0;
    logic [7:0] last_data = 8'h00;
    logic       cs_q = 1'b1;

`ifdef DAC_TRIANGLE_EN
    localparam logic [7:0] RAMP2 = 8'hFE;
`else
    localparam logic [7:0] RAMP2 = 8'h00;
`endif

    dac_write_ctrl #(.RAMP_DIV(16)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_mid(btn_mid),
        .ramp_en(ramp_en), .dac_cs_n(dac_cs_n), .dac_wr_n(dac_wr_n), .dac_data(dac_data),
        .dac_val(dac_val), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // counts write starts (cs_n falling) and captures the data presented at each start
    always @(negedge clk) begin
        if (cs_q && !dac_cs_n) begin
            wr_count++;
            last_data = dac_data;
        end
        cs_q = dac_cs_n;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_count(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (wr_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_val(input logic [7:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            step();
            if (dac_val == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ramp_to(input logic [7:0] target, output bit ok);
        bit ok2;
        ramp_en = 1'b1;
        wait_val(target, ok);
        ramp_en = 1'b0;
        wait_done(ok2);
        ok = ok & ok2;
        repeat (3) step();
    endtask

    task automatic test_reset();
        bit found = 1'b0;
        logic [7:0] cs_bits, wr_bits, done_bits, busy_bits;
        logic data_ok = 1'b1;
        rst = 1'b0;
        repeat (3) step();
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", dac_cs_n); end
        checks++; if (dac_wr_n !== 1'b1) begin failures++; $display("FAIL reset_wr_n got=%b exp=1", dac_wr_n); end
        checks++; if (dac_data !== 8'h80) begin failures++; $display("FAIL reset_data got=%h exp=80", dac_data); end
        checks++; if (dac_val !== 8'h80) begin failures++; $display("FAIL reset_val got=%h exp=80", dac_val); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!dac_cs_n) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL init_start got=%b exp=1", found); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            cs_bits[i]   = dac_cs_n;
            wr_bits[i]   = dac_wr_n;
            done_bits[i] = done;
            busy_bits[i] = busy;
            if (i < 7 && dac_data !== 8'h80) data_ok = 1'b0;
        end
        checks++; if (cs_bits !== 8'h80) begin failures++; $display("FAIL init_cs_pattern got=%b exp=10000000", cs_bits); end
        checks++; if (wr_bits !== 8'hE3) begin failures++; $display("FAIL init_wr_pattern got=%b exp=11100011", wr_bits); end
        checks++; if (done_bits !== 8'h80) begin failures++; $display("FAIL init_done_pattern got=%b exp=10000000", done_bits); end
        checks++; if (busy_bits !== 8'h7F) begin failures++; $display("FAIL init_busy_pattern got=%b exp=01111111", busy_bits); end
        checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL init_data got=%b exp=1", data_ok); end
        repeat (3) step();
    endtask

    task automatic test_up();
        int n = 0;
        bit ok;
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (!dac_cs_n) break;
        end
        btn_up = 1'b0;
        checks++; if (n !== 3) begin failures++; $display("FAIL up_latency got=%0d exp=3", n); end
        for (int i = 0; i < 5 && dac_wr_n; i++) step();
        btn_up = 1'b1;
        repeat (3) step();
        btn_up = 1'b0;
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL up1_done got=%b exp=1", ok); end
        checks++; if (dac_val !== 8'h81) begin failures++; $display("FAIL up1_val got=%h exp=81", dac_val); end
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("FAIL up_idle_cs got=%b exp=1", dac_cs_n); end
        step();
        checks++; if (dac_cs_n !== 1'b0) begin failures++; $display("FAIL up_b2b_cs got=%b exp=0", dac_cs_n); end
        checks++; if (dac_data !== 8'h82) begin failures++; $display("FAIL up2_data got=%h exp=82", dac_data); end
        wait_done(ok);
        checks++; if (dac_val !== 8'h82 || !ok) begin failures++; $display("FAIL up2_val got=%h exp=82", dac_val); end
        repeat (3) step();
    endtask

    task automatic test_mid_up();
        bit ok;
        int base;
        btn_down = 1'b1;
        repeat (3) step();
        btn_down = 1'b0;
        btn_up   = 1'b1;
        btn_mid  = 1'b1;
        repeat (3) step();
        btn_up  = 1'b0;
        btn_mid = 1'b0;
        wait_done(ok);
        checks++; if (dac_val !== 8'h81 || !ok) begin failures++; $display("FAIL down_val got=%h exp=81", dac_val); end
        step();
        checks++; if (dac_cs_n !== 1'b0) begin failures++; $display("FAIL mid_start got=%b exp=0", dac_cs_n); end
        checks++; if (dac_data !== 8'h80) begin failures++; $display("FAIL mid_data got=%h exp=80", dac_data); end
        wait_done(ok);
        base = wr_count;
        repeat (30) step();
        checks++; if (wr_count !== base) begin failures++; $display("FAIL mid_up_discard got=%0d exp=%0d", wr_count, base); end
        checks++; if (dac_val !== 8'h80) begin failures++; $display("FAIL mid_val got=%h exp=80", dac_val); end
    endtask

    task automatic test_up_down();
        int base = wr_count;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        repeat (3) step();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (30) step();
        checks++; if (wr_count !== base) begin failures++; $display("FAIL updown_writes got=%0d exp=%0d", wr_count, base); end
        checks++; if (dac_val !== 8'h80) begin failures++; $display("FAIL updown_val got=%h exp=80", dac_val); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL updown_busy got=%b exp=0", busy); end
    endtask

    task automatic test_saturate();
        bit ok;
        int base;
        ramp_to(8'hFF, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ramp_to_ff got=%b exp=1", ok); end
        base = wr_count;
        btn_up = 1'b1;
        repeat (3) step();
        btn_up = 1'b0;
        wait_done(ok);
        checks++; if (wr_count !== base + 1 || !ok) begin failures++; $display("FAIL sat_up_write got=%0d exp=%0d", wr_count, base + 1); end
        checks++; if (dac_val !== 8'hFF) begin failures++; $display("FAIL sat_up_val got=%h exp=ff", dac_val); end
        ramp_to(8'h00, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ramp_to_00 got=%b exp=1", ok); end
        base = wr_count;
        btn_down = 1'b1;
        repeat (3) step();
        btn_down = 1'b0;
        wait_done(ok);
        checks++; if (wr_count !== base + 1 || !ok) begin failures++; $display("FAIL sat_down_write got=%0d exp=%0d", wr_count, base + 1); end
        checks++; if (dac_val !== 8'h00) begin failures++; $display("FAIL sat_down_val got=%h exp=00", dac_val); end
        repeat (3) step();
    endtask

    task automatic test_ramp();
        bit ok;
        int base;
        ramp_en = 1'b1;
        wait_val(8'hFE, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ramp_reach_fe got=%b exp=1", ok); end
        base = wr_count;
        btn_up = 1'b1;
        repeat (3) step();
        btn_up = 1'b0;
        wait_count(base + 1, ok);
        checks++; if (last_data !== 8'hFF || !ok) begin failures++; $display("FAIL ramp_step1 got=%h exp=ff", last_data); end
        wait_count(base + 2, ok);
        checks++; if (last_data !== RAMP2 || !ok) begin failures++; $display("FAIL ramp_step2 got=%h exp=%h", last_data, RAMP2); end
        ramp_en = 1'b0;
        wait_done(ok);
        base = wr_count;
        repeat (40) step();
        checks++; if (wr_count !== base) begin failures++; $display("FAIL ramp_up_ignored got=%0d exp=%0d", wr_count, base); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base;
        btn_up = 1'b1;
        repeat (3) step();
        btn_up = 1'b0;
        for (int i = 0; i < 6 && dac_wr_n; i++) step();
        checks++; if (dac_wr_n !== 1'b0) begin failures++; $display("FAIL rstmid_strobe got=%b exp=0", dac_wr_n); end
        rst = 1'b0;
        #1;
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("FAIL rstmid_cs got=%b exp=1", dac_cs_n); end
        checks++; if (dac_wr_n !== 1'b1) begin failures++; $display("FAIL rstmid_wr got=%b exp=1", dac_wr_n); end
        checks++; if (dac_val !== 8'h80) begin failures++; $display("FAIL rstmid_val got=%h exp=80", dac_val); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        step();
        rst = 1'b1;
        base = wr_count;
        wait_done(ok);
        checks++; if (wr_count !== base + 1 || !ok) begin failures++; $display("FAIL rstmid_init_write got=%0d exp=%0d", wr_count, base + 1); end
        checks++; if (last_data !== 8'h80) begin failures++; $display("FAIL rstmid_init_data got=%h exp=80", last_data); end
    endtask

    initial begin
        test_reset();
        test_up();
        test_mid_up();
        test_up_down();
        test_saturate();
        test_ramp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
